// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, LSB first, one bit per clk.
// Feeds a downstream SIPO; word_done pulses when that SIPO holds the full word.
// Optional feature macro: PISO_TX_PARITY_EN appends an even-parity bit to each frame.
module piso_tx #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             busy,
  output logic             word_done
);

`ifdef PISO_TX_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int              CW       = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]   LAST     = CW'(FRAME - 1);
  localparam logic [7:0]      GAP_LAST = 8'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state;
  logic [WIDTH-2:0] sr;    // bits still to be sent after the one currently on so
  logic [CW-1:0]    cnt;   // index of the bit currently on so
  logic [7:0]       gcnt;  // gap cycles elapsed
`ifdef PISO_TX_PARITY_EN
  logic             par;
`endif
  logic             last_bit;
  logic             accept;

  assign last_bit = (state == SHIFT) && (cnt == LAST);
  assign accept   = din_valid && din_ready;

  // Ready in IDLE, or on the final cycle of the frame/gap so words stream back-to-back
  always_comb begin
    din_ready = 1'b0;
    if (!rst) begin
      if (state == IDLE)         din_ready = 1'b1;
      else if (GAP_CYCLES == 0)  din_ready = last_bit;
      else                       din_ready = (state == GAP) && (gcnt == GAP_LAST);
    end
  end

  // Frame FSM: accept/shift/gap with registered so, busy and word_done
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      so        <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      // The SIPO has taken its last bit at the edge ending the last bit cycle
      word_done <= last_bit;
      if (accept) begin
        sr    <= din[WIDTH-1:1];
        so    <= din[0];
        cnt   <= '0;
        gcnt  <= '0;
        state <= SHIFT;
        busy  <= 1'b1;
`ifdef PISO_TX_PARITY_EN
        par   <= ^din;
`endif
      end else begin
        case (state)
          SHIFT: begin
            if (last_bit) begin
              so <= 1'b0;
              if (GAP_CYCLES == 0) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= GAP;
                gcnt  <= '0;
              end
            end else begin
`ifdef PISO_TX_PARITY_EN
              so <= (cnt == CW'(WIDTH - 1)) ? par : sr[0];
`else
              so <= sr[0];
`endif
              sr  <= sr >> 1;
              cnt <= cnt + CW'(1);
            end
          end
          GAP: begin
            if (gcnt == GAP_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              gcnt <= gcnt + 8'd1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed bench for piso_tx (default instance plus a GAP_CYCLES=3 instance).
module tb_piso_tx;
  localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready, so, busy, word_done;
  logic [W-1:0] din_g = '0;
  logic         valid_g = 1'b0;
  logic         ready_g, so_g, busy_g, wd_g;
  logic [W-1:0] sipo = '0;
  int           total = 0;
  int           bad   = 0;

  piso_tx #(.WIDTH(W), .GAP_CYCLES(0)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .so(so), .busy(busy), .word_done(word_done));

  piso_tx #(.WIDTH(W), .GAP_CYCLES(3)) u_gap (
    .clk(clk), .rst(rst), .din(din_g), .din_valid(valid_g), .din_ready(ready_g),
    .so(so_g), .busy(busy_g), .word_done(wd_g));

  always #5 clk = ~clk;

  // downstream SIPO model: LSB-first stream ends with bit 0 in q[0]
  always @(posedge clk) sipo <= {so, sipo[W-1:1]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // expected bit i of a frame: data bits LSB first, then the parity bit if enabled
  function automatic logic fbit(input logic [W-1:0] w, input int i);
    return (i < W) ? w[i] : ^w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // send one word on the default instance and check the whole frame plus word_done
  task automatic send_frame(input string tag, input logic [W-1:0] w);
    din = w;
    din_valid = 1'b1;
    #1 chk({tag, "_rdy"}, din_ready, 1'b1);
    tick;
    din_valid = 1'b0;
    din = '0;
    for (int i = 0; i < F; i++) begin
      chk({tag, "_so"}, so, fbit(w, i));
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_wd0"}, word_done, 1'b0);
      tick;
    end
    chk({tag, "_wd1"}, word_done, 1'b1);
    chk({tag, "_so_idle"}, so, 1'b0);
    chk({tag, "_busy_end"}, busy, 1'b0);
`ifndef PISO_TX_PARITY_EN
    chk({tag, "_sipo"}, sipo, w);
`endif
    tick;
    chk({tag, "_wd_pulse"}, word_done, 1'b0);
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    tick;
    tick;
    chk("rst_so", so, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wd", word_done, 1'b0);
    chk("rst_rdy", din_ready, 1'b0);
    chk("rst_rdy_g", ready_g, 1'b0);
    rst = 1'b0;

    // single word 1011 -> so 1,1,0,1 then word_done, SIPO holds 1011
    send_frame("t1", 4'b1011);

    // back-to-back A then 5: 0,1,0,1,1,0,1,0 with no idle bit
    din = 4'hA;
    din_valid = 1'b1;
    tick;
    din = 4'h5;
    for (int i = 0; i < F; i++) begin
      chk("b2b_so_a", so, fbit(4'hA, i));
      chk("b2b_rdy", din_ready, (i == F - 1) ? 1'b1 : 1'b0);
      tick;
    end
    din_valid = 1'b0;
    chk("b2b_wd_a", word_done, 1'b1);
    for (int i = 0; i < F; i++) begin
      chk("b2b_so_5", so, fbit(4'h5, i));
      if (i > 0) chk("b2b_wd_gap", word_done, 1'b0);
      tick;
    end
    chk("b2b_wd_5", word_done, 1'b1);
    chk("b2b_busy_end", busy, 1'b0);
`ifndef PISO_TX_PARITY_EN
    chk("b2b_sipo", sipo, 4'h5);
`endif
    tick;

    // GAP_CYCLES=3: 6 then 9 queued, three so=0 / not-ready cycles between frames
    din_g = 4'h6;
    valid_g = 1'b1;
    tick;
    din_g = 4'h9;
    for (int i = 0; i < F; i++) begin
      chk("gap_so_6", so_g, fbit(4'h6, i));
      chk("gap_rdy_shift", ready_g, 1'b0);
      tick;
    end
    for (int j = 0; j < 3; j++) begin
      chk("gap_so0", so_g, 1'b0);
      chk("gap_busy", busy_g, 1'b1);
      chk("gap_rdy", ready_g, (j == 2) ? 1'b1 : 1'b0);
      chk("gap_wd", wd_g, (j == 0) ? 1'b1 : 1'b0);
      tick;
    end
    valid_g = 1'b0;
    for (int i = 0; i < F; i++) begin
      chk("gap_so_9", so_g, fbit(4'h9, i));
      chk("gap_wd_mid", wd_g, 1'b0);
      tick;
    end
    chk("gap_wd_9", wd_g, 1'b1);
    tick;
    tick;
    tick;
    chk("gap_idle_rdy", ready_g, 1'b1);
    chk("gap_idle_busy", busy_g, 1'b0);

    // reset on the 2nd bit of F aborts the frame without word_done
    din = 4'hF;
    din_valid = 1'b1;
    tick;
    din_valid = 1'b0;
    chk("rmf_b0", so, 1'b1);
    tick;
    chk("rmf_b1", so, 1'b1);
    rst = 1'b1;
    #1 chk("rmf_rdy_rst", din_ready, 1'b0);
    tick;
    rst = 1'b0;
    chk("rmf_so", so, 1'b0);
    chk("rmf_busy", busy, 1'b0);
    chk("rmf_wd", word_done, 1'b0);
    for (int k = 0; k < F; k++) begin
      tick;
      chk("rmf_no_wd", word_done, 1'b0);
    end
    send_frame("rmf3", 4'h3);

    // backpressure: din changes every cycle, only the value at the ready edge is taken
    din = 4'h1;
    din_valid = 1'b1;
    tick;
    for (int i = 0; i < F; i++) begin
      chk("bp_so_1", so, fbit(4'h1, i));
      din = (i == F - 1) ? 4'hC : (4'hF ^ 4'(i));
      tick;
    end
    din_valid = 1'b0;
    din = 4'h7;
    for (int i = 0; i < F; i++) begin
      chk("bp_so_c", so, fbit(4'hC, i));
      din = 4'(i + 5);
      tick;
    end
    chk("bp_wd", word_done, 1'b1);
`ifndef PISO_TX_PARITY_EN
    chk("bp_sipo", sipo, 4'hC);
`endif
    tick;

`ifdef PISO_TX_PARITY_EN
    // 0111 -> 1,1,1,0 then parity 1; 0011 -> parity 0
    din = 4'b0111;
    din_valid = 1'b1;
    tick;
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    chk("par_0111", so, 1'b1);
    tick;
    chk("par_wd", word_done, 1'b1);
    tick;
    din = 4'b0011;
    din_valid = 1'b1;
    tick;
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    chk("par_0011", so, 1'b0);
    tick;
    chk("par_wd2", word_done, 1'b1);
    tick;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
